spare_combo_generator: RTL and testbench

//  Parametrised, handshaked enumerator of spare-allocation test patterns for the repair-analysis datapath.

---
 rtl/spare_combo_generator.sv | 163 ++++++++++++++++
 tb/tb_spare_combo_generator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spare_combo_generator.sv
// Handshaked enumerator of K-of-N spare-select patterns (dsss, optionally nested with rlss).
// Define SPARE_GEN_IDX_EN to add the seq_idx pattern-ordinal output.

module spare_combo_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] cur,
    output logic [N-1:0] nxt
);
    logic found;
    int   pos;
    int   ones;

    // Next smaller value with the same popcount: find the lowest 1 with a 0 below it,
    // move it down one place and pack the trailing ones directly beneath it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        nxt   = '0;
        found = 1'b0;
        pos   = 0;
        ones  = 0;
        for (int i = 1; i < N; i++) begin
            if (!found) begin
                if (cur[i-1]) ones = ones + 1;
                if (cur[i] && !cur[i-1]) begin
                    found = 1'b1;
                    pos   = i;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            if (j > pos)                            nxt[j] = cur[j];
            else if (j < pos && j >= pos - 1 - ones) nxt[j] = 1'b1;
        end
    end
endmodule

module spare_combo_generator #(
    parameter int N_DS  = 8,
    parameter int K_DS  = 4,
    parameter int N_RL  = 4,
    parameter int K_RL  = 2,
    parameter int IDX_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      mode,
    input  logic            ready,
    output logic            valid,
    output logic [N_DS-1:0] dsss,
    output logic [N_RL-1:0] rlss,
    output logic            last,
    output logic            done,
    output logic            busy
`ifdef SPARE_GEN_IDX_EN
    ,
    output logic [IDX_W-1:0] seq_idx
`endif
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [N_DS-1:0] DS_ALL   = '1;
    localparam logic [N_DS-1:0] DS_FIRST = ~(DS_ALL >> K_DS);
    localparam logic [N_DS-1:0] DS_LAST  = DS_ALL >> (N_DS - K_DS);
    localparam logic [N_RL-1:0] RL_ALL   = '1;
    localparam logic [N_RL-1:0] RL_FIRST = ~(RL_ALL >> K_RL);
    localparam logic [N_RL-1:0] RL_LAST  = RL_ALL >> (N_RL - K_RL);

    state_t          state, state_n;
    logic            nested, nested_n;
    logic [N_DS-1:0] dsss_n, ds_step;
    logic [N_RL-1:0] rlss_n, rl_step;
    logic            done_n;
    logic            ds_at_last, rl_at_last;

    spare_combo_step #(.N(N_DS)) u_ds_step (.cur(dsss), .nxt(ds_step));
    spare_combo_step #(.N(N_RL)) u_rl_step (.cur(rlss), .nxt(rl_step));

    assign ds_at_last = (dsss == DS_LAST);
    assign rl_at_last = (rlss == RL_LAST);
    assign valid      = (state == S_RUN);
    assign busy       = valid;
    assign last       = valid && ds_at_last && (!nested || rl_at_last);

    always_comb begin
        state_n  = state;
        nested_n = nested;
        dsss_n   = dsss;
        rlss_n   = rlss;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (mode != 2'b00) begin
                        state_n  = S_RUN;
                        nested_n = (mode == 2'b11);
                        dsss_n   = DS_FIRST;
                        rlss_n   = (mode == 2'b11) ? RL_FIRST : '0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    dsss_n  = '0;
                    rlss_n  = '0;
                end else if (ready) begin
                    if (last) begin
                        state_n = S_IDLE;
                        dsss_n  = '0;
                        rlss_n  = '0;
                        done_n  = 1'b1;
                    end else if (nested) begin
                        // rlss is the inner loop; wrapping it carries into dsss
                        if (rl_at_last) begin
                            rlss_n = RL_FIRST;
                            dsss_n = ds_step;
                        end else begin
                            rlss_n = rl_step;
                        end
                    end else begin
                        dsss_n = ds_step;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state  <= S_IDLE;
            nested <= 1'b0;
            dsss   <= '0;
            rlss   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            nested <= nested_n;
            dsss   <= dsss_n;
            rlss   <= rlss_n;
            done   <= done_n;
        end
    end

`ifdef SPARE_GEN_IDX_EN
    // Idles at zero, so the first pattern of any sweep is always ordinal 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_idx <= '0;
        end else if (valid && (abort || (ready && last))) begin
            seq_idx <= '0;
        end else if (valid && ready) begin
            seq_idx <= seq_idx + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spare_combo_generator.sv
// Scoreboard bench for spare_combo_generator (default parameters); checks seq_idx when SPARE_GEN_IDX_EN is defined.

module tb_spare_combo_generator;
    localparam int N_DS = 8, K_DS = 4, N_RL = 4, K_RL = 2, IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, abort, ready;
    logic [1:0]       mode;
    logic             valid, last, done, busy;
    logic [N_DS-1:0]  dsss;
    logic [N_RL-1:0]  rlss;
`ifdef SPARE_GEN_IDX_EN
    logic [IDX_W-1:0] seq_idx;
`endif

    spare_combo_generator #(
        .N_DS(N_DS), .K_DS(K_DS), .N_RL(N_RL), .K_RL(K_RL), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .ready(ready),
        .valid(valid), .dsss(dsss), .rlss(rlss), .last(last), .done(done), .busy(busy)
`ifdef SPARE_GEN_IDX_EN
        , .seq_idx(seq_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ds;
        logic [3:0]  rl;
        logic        lst;
        logic [15:0] idx;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // {valid, busy, last, done, dsss, rlss}
    function automatic logic [15:0] obs();
        return {valid, busy, last, done, dsss, rlss};
    endfunction

    // Expected sequence from a brute-force descending scan filtered by popcount.
    task automatic build_expected(input bit nested_m);
        logic [7:0] ds_l[$];
        logic [3:0] rl_l[$];
        logic [7:0] bd;
        logic [3:0] br;
        beat_t      b;
        int         idx;
        q.delete();
        for (int v = 255; v >= 0; v--) begin
            bd = 8'(v);
            if ($countones(bd) == K_DS) ds_l.push_back(bd);
        end
        for (int v = 15; v >= 0; v--) begin
            br = 4'(v);
            if ($countones(br) == K_RL) rl_l.push_back(br);
        end
        idx = 0;
        foreach (ds_l[i]) begin
            if (nested_m) begin
                foreach (rl_l[j]) begin
                    b.ds = ds_l[i]; b.rl = rl_l[j]; b.lst = 1'b0; b.idx = 16'(idx);
                    q.push_back(b);
                    idx++;
                end
            end else begin
                b.ds = ds_l[i]; b.rl = 4'h0; b.lst = 1'b0; b.idx = 16'(idx);
                q.push_back(b);
                idx++;
            end
        end
        q[q.size()-1].lst = 1'b1;
    endtask

    // Runs one sweep against the scoreboard; optionally aborts or resets after a number of accepts.
    task automatic run_sweep(input string name, input logic [1:0] m, input bit rand_ready,
                             input int abort_at, input int rst_at);
        beat_t e;
        bit    r, finished;
        int    accepts;
        build_expected(m == 2'b11);
        accepts  = 0;
        finished = 1'b0;
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (accepts == abort_at) begin
                abort = 1'b1; ready = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                n_cmp++;
                if (obs() !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL %s abort_out: got %h want 0000", name, obs());
                end
                @(negedge clk);
                n_cmp++;
                if (done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s abort_no_done: got done=%b want 0", name, done);
                end
`ifdef SPARE_GEN_IDX_EN
                n_cmp++;
                if (seq_idx !== 16'd0) begin
                    n_bad++;
                    $display("FAIL %s abort_idx: got %0d want 0", name, seq_idx);
                end
`endif
                q.delete();
                return;
            end
            if (accepts == rst_at) begin
                rst = 1'b1; ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                n_cmp++;
                if (obs() !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL %s reset_out: got %h want 0000", name, obs());
                end
`ifdef SPARE_GEN_IDX_EN
                n_cmp++;
                if (seq_idx !== 16'd0) begin
                    n_bad++;
                    $display("FAIL %s reset_idx: got %0d want 0", name, seq_idx);
                end
`endif
                q.delete();
                return;
            end
            e = q[0];
            n_cmp++;
            if (obs() !== {1'b1, 1'b1, e.lst, 1'b0, e.ds, e.rl}) begin
                n_bad++;
                $display("FAIL %s beat%0d: got v/b/l/d/ds/rl=%h want %h", name, e.idx, obs(),
                         {1'b1, 1'b1, e.lst, 1'b0, e.ds, e.rl});
            end
`ifdef SPARE_GEN_IDX_EN
            n_cmp++;
            if (seq_idx !== e.idx) begin
                n_bad++;
                $display("FAIL %s idx: got %0d want %0d", name, seq_idx, e.idx);
            end
`endif
            r     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = r;
            // Noise that must be ignored while running.
            mode  = 2'($urandom);
            start = rand_ready && ($urandom_range(0, 7) == 0) && !(e.lst && r);
            if (r) begin
                void'(q.pop_front());
                accepts++;
                if (e.lst) finished = 1'b1;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        start = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d accepts want %0d", name, accepts, accepts + q.size());
            return;
        end
        n_cmp++;
        if (obs() !== 16'h1000) begin
            n_bad++;
            $display("FAIL %s done_pulse: got %h want 1000", name, obs());
        end
`ifdef SPARE_GEN_IDX_EN
        n_cmp++;
        if (seq_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL %s done_idx: got %0d want 0", name, seq_idx);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (obs() !== 16'h0000) begin
            n_bad++;
            $display("FAIL %s after_done: got %h want 0000", name, obs());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'b11; ready = 1'b1; abort = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want 0000", obs());
        end
        rst = 1'b0; start = 1'b0; ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs() !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release: got %h want 0000", obs());
        end
`ifdef SPARE_GEN_IDX_EN
        n_cmp++;
        if (seq_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_idx: got %0d want 0", seq_idx);
        end
`endif
    endtask

    task automatic test_dsss_only();
        run_sweep("t1_dsss", 2'b01, 1'b0, -1, -1);
        run_sweep("t1_dsss_m10", 2'b10, 1'b0, -1, -1);
    endtask

    task automatic test_nested();
        run_sweep("t2_nested", 2'b11, 1'b0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_sweep("t3_bp", 2'b01, 1'b1, -1, -1);
        run_sweep("t3_bp_nested", 2'b11, 1'b1, -1, -1);
    endtask

    task automatic test_abort();
        run_sweep("t4_abort", 2'b01, 1'b0, 10, -1);
        run_sweep("t4_restart", 2'b01, 1'b0, -1, -1);
        // abort together with start in IDLE: abort wins, nothing starts
        start = 1'b1; abort = 1'b1; mode = 2'b01;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (obs() !== 16'h0000) begin
            n_bad++;
            $display("FAIL t4_abort_start: got %h want 0000", obs());
        end
    endtask

    task automatic test_reset_mid();
        run_sweep("t5_rst", 2'b11, 1'b0, -1, 100);
        run_sweep("t5_restart", 2'b11, 1'b0, -1, -1);
    endtask

    task automatic test_mode_none();
        start = 1'b1; mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (obs() !== 16'h1000) begin
            n_bad++;
            $display("FAIL t6_done: got %h want 1000", obs());
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== 16'h0000) begin
                n_bad++;
                $display("FAIL t6_idle%0d: got %h want 0000", i, obs());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; mode = 2'b00;
        @(negedge clk);
        test_reset();
        test_dsss_only();
        test_nested();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_mode_none();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
